output_bram_drain: RTL and testbench

OUTPUT_BRAM_DRAIN -- requirements
Module: output_bram_drain

---
 rtl/output_drain_pkg.sv | 17 +
 rtl/drain_row_serializer.sv | 74 +++++++
 rtl/output_bram_drain.sv | 104 ++++++++++
 tb/tb_output_bram_drain.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/output_drain_pkg.sv
// Shared state encoding and default sizing for the output BRAM drain.
package output_drain_pkg;

  localparam int DEF_DW         = 16;
  localparam int DEF_NUM_BRAMS  = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_e;

endpackage

// File: rtl/drain_row_serializer.sv
// Row buffer plus AXI-Stream serializer: one captured BRAM row out, BRAM 0 first.
// OUTPUT_DRAIN_RELU_EN: clamp negative (signed) words to zero on load.
module drain_row_serializer
  import output_drain_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int NUM_BRAMS = DEF_NUM_BRAMS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    last_row,
  input  logic [NUM_BRAMS*DW-1:0] row_data_flat,
  output logic [DW-1:0]           m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    row_done
);

  localparam int IDX_W = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRAMS - 1);

  logic [NUM_BRAMS-1:0][DW-1:0] row_buf;
  logic [NUM_BRAMS-1:0][DW-1:0] load_words;
  logic [IDX_W-1:0]             word_idx;
  logic [IDX_W-1:0]             next_idx;
  logic                         last_row_q;
  logic                         hs;

  for (genvar k = 0; k < NUM_BRAMS; k++) begin : g_word
    logic [DW-1:0] raw;
    assign raw = row_data_flat[k*DW +: DW];
`ifdef OUTPUT_DRAIN_RELU_EN
    assign load_words[k] = raw[DW-1] ? '0 : raw;
`else
    assign load_words[k] = raw;
`endif
  end

  assign hs       = m_axis_tvalid & m_axis_tready;
  assign row_done = hs & (word_idx == LAST_IDX);
  assign next_idx = word_idx + 1'b1;

  // tdata/tlast only move on a handshake, so a stalled beat stays put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_buf       <= '0;
      word_idx      <= '0;
      last_row_q    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      row_buf       <= load_words;
      word_idx      <= '0;
      last_row_q    <= last_row;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_words[0];
      m_axis_tlast  <= last_row & (LAST_IDX == '0);
    end else if (hs) begin
      if (word_idx == LAST_IDX) begin
        word_idx      <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else begin
        word_idx      <= next_idx;
        m_axis_tdata  <= row_buf[next_idx];
        m_axis_tlast  <= last_row_q & (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/output_bram_drain.sv
// Drains rows of the output BRAM array onto AXI-Stream: FSM, row address and row count.
// OUTPUT_DRAIN_RELU_EN (in drain_row_serializer) clamps negative words to zero.
module output_bram_drain
  import output_drain_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int NUM_BRAMS  = DEF_NUM_BRAMS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_rows,
  output logic                            ext_read_mode,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
  output logic [NUM_BRAMS-1:0]            ext_read_en,
  input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
  output logic [DW-1:0]                   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done
);

  localparam logic [ADDR_WIDTH:0] ONE_ROW = 1;

  drain_state_e          state;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH:0]   rows_left;
  logic                  row_done;

  // Address is a full ADDR_WIDTH register, so +1 wraps modulo DEPTH for free.
  assign ext_read_addr_flat = {NUM_BRAMS{row_addr}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      row_addr      <= '0;
      rows_left     <= '0;
      ext_read_mode <= 1'b0;
      ext_read_en   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      ext_read_en <= '0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy      <= 1'b1;
          row_addr  <= base_addr;
          rows_left <= num_rows;
          if (num_rows == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state         <= ST_READ;
            ext_read_mode <= 1'b1;
            ext_read_en   <= '1;
          end
        end
        ST_READ:    state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_STREAM;
        ST_STREAM: if (row_done) begin
          if (rows_left > ONE_ROW) begin
            state       <= ST_READ;
            ext_read_en <= '1;
            row_addr    <= row_addr + 1'b1;
            rows_left   <= rows_left - 1'b1;
          end else begin
            state         <= ST_DONE;
            ext_read_mode <= 1'b0;
            rows_left     <= '0;
            done          <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  drain_row_serializer #(
    .DW        (DW),
    .NUM_BRAMS (NUM_BRAMS)
  ) u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (state == ST_CAPTURE),
    .last_row      (rows_left == ONE_ROW),
    .row_data_flat (bram_read_data_flat),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .row_done      (row_done)
  );

endmodule

// File: tb/tb_output_bram_drain.sv
// Directed bench for output_bram_drain with a behavioural 1-cycle-latency BRAM array.
module tb_output_bram_drain;
  localparam int DW = 16, NB = 16, AW = 9, DEPTH = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       num_rows;
  logic              ext_read_mode;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic [NB-1:0]     ext_read_en;
  logic [NB*DW-1:0]  bram_read_data_flat;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic              busy, done;

  int checks = 0, errors = 0;
  logic [DW-1:0] mem [NB][DEPTH];

  logic [DW-1:0] beats[$];
  logic          lasts[$];
  int            rd_rows[$];
  int            first_valid, last_hs, done_cyc;

  always #5 clk = ~clk;

  output_bram_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .ext_read_mode(ext_read_mode), .ext_read_addr_flat(ext_read_addr_flat),
    .ext_read_en(ext_read_en), .bram_read_data_flat(bram_read_data_flat),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done)
  );

  always @(posedge clk)
    for (int k = 0; k < NB; k++)
      if (ext_read_en[k])
        bram_read_data_flat[k*DW +: DW] <= mem[k][ext_read_addr_flat[k*AW +: AW]];

  function automatic logic [DW-1:0] pat(input int r, input int k);
    logic [7:0] rr;
    logic [4:0] kk;
    rr = 8'(r);
    kk = 5'(k + 1);
    return {1'b0, rr, 2'b00, kk};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one drain; abort_beat>0 returns just before that beat's handshake edge.
  task automatic run_drain(input logic [AW-1:0] base, input logic [AW:0] rows,
                           input bit toggle, input bit poke, input int abort_beat);
    bit            stalled = 0;
    bit            fin = 0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    beats.delete(); lasts.delete(); rd_rows.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_rows = rows; m_axis_tready = 1'b1;
    for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && cyc == 5) begin
        start = 1'b1; base_addr = 9'd100; num_rows = 10'd7;
      end
      m_axis_tready = toggle ? cyc[0] : 1'b1;
      if (stalled) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", 32'(m_axis_tdata), 32'(pd));
        chk("stall_last", 32'(m_axis_tlast), 32'(pl));
      end
      if (ext_read_en != '0) begin
        chk("read_en_all", 32'(ext_read_en), 32'hFFFF);
        chk("read_mode_rd", 32'(ext_read_mode), 32'd1);
        for (int k = 1; k < NB; k++)
          chk("addr_bcast", 32'(ext_read_addr_flat[k*AW +: AW]), 32'(ext_read_addr_flat[AW-1:0]));
        rd_rows.push_back(int'(ext_read_addr_flat[AW-1:0]));
      end
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back(m_axis_tdata);
        lasts.push_back(m_axis_tlast);
        last_hs = cyc;
        if (abort_beat > 0 && beats.size() == abort_beat) return;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      if (done) begin
        done_cyc = cyc;
        chk("mode_in_done", 32'(ext_read_mode), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    chk({tag, "_mode"}, 32'(ext_read_mode), 32'd0);
    chk({tag, "_en"}, 32'(ext_read_en), 32'd0);
    chk({tag, "_addr_or"}, 32'(|ext_read_addr_flat), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_beats(input string tag, input int base, input int nrows);
    chk({tag, "_count"}, 32'(beats.size()), 32'(nrows * NB));
    chk({tag, "_reads"}, 32'(rd_rows.size()), 32'(nrows));
    for (int i = 0; i < beats.size() && i < nrows * NB; i++) begin
      chk({tag, "_data"}, 32'(beats[i]), 32'(pat((base + i / NB) % DEPTH, i % NB)));
      chk({tag, "_last"}, 32'(lasts[i]), 32'(i == nrows * NB - 1));
    end
    for (int r = 0; r < rd_rows.size() && r < nrows; r++)
      chk({tag, "_row"}, 32'(rd_rows[r]), 32'((base + r) % DEPTH));
  endtask

  initial begin
    for (int k = 0; k < NB; k++)
      for (int r = 0; r < DEPTH; r++)
        mem[k][r] = pat(r, k);
    mem[3][20] = 16'hFFF0;
    mem[4][20] = 16'h7FFF;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // single row, values k+1; a start poked mid-drain must be ignored
    run_drain(9'd0, 10'd1, 1'b0, 1'b1, 0);
    chk_beats("row0", 0, 1);
    chk("row0_beat1", 32'(beats[0]), 32'd1);
    chk("row0_beat16", 32'(beats[15]), 32'd16);
    chk("latency", 32'(first_valid), 32'd3);
    chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));

    // address wrap 510, 511, 0 and back-to-back throughput
    run_drain(9'd510, 10'd3, 1'b0, 1'b0, 0);
    chk_beats("wrap", 510, 3);
    chk("throughput", 32'(last_hs - first_valid), 32'(3 * NB + 2 * 2 - 1));

    // tready toggling every cycle
    run_drain(9'd5, 10'd2, 1'b1, 1'b0, 0);
    chk_beats("toggle", 5, 2);

    // zero rows: no beats, no reads, immediate done
    run_drain(9'd40, 10'd0, 1'b0, 1'b0, 0);
    chk("zero_beats", 32'(beats.size()), 32'd0);
    chk("zero_reads", 32'(rd_rows.size()), 32'd0);
    chk("zero_done", 32'(done_cyc), 32'd1);

    // reset mid-stream at beat 7 of row 0
    run_drain(9'd0, 10'd2, 1'b0, 1'b0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midrst");
    rst_n = 1'b1;
    run_drain(9'd0, 10'd1, 1'b0, 1'b0, 0);
    chk_beats("after_rst", 0, 1);

    // negative word in BRAM 3 at row 20
    run_drain(9'd20, 10'd1, 1'b0, 1'b0, 0);
    chk("relu_count", 32'(beats.size()), 32'd16);
`ifdef OUTPUT_DRAIN_RELU_EN
    chk("relu_beat4", 32'(beats[3]), 32'h0000);
`else
    chk("relu_beat4", 32'(beats[3]), 32'hFFF0);
`endif
    chk("relu_beat5", 32'(beats[4]), 32'h7FFF);
    chk("relu_beat3", 32'(beats[2]), 32'(pat(20, 2)));
    chk("relu_last", 32'(lasts[15]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
